mem_access_unit: RTL

- Memory-stage load/store initiator. Takes one load/store from the ex_mem pipeline register and issues it as a request/response transaction to the data memory responder.
- Stalls the pipeline until the responder answers, then returns read data to mem_wb.
- Handles byte/word sizing, lane alignment and little-endian byte placement on the initiator side.
- The responder only sees word-aligned addresses with byte enables.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_access_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory-stage load/store initiator.
//   state_t : initiator FSM states (IDLE, REQ, WAIT, DONE)
//   size_t  : access size (BYTE = 0, WORD = 1)
//   BE_WORD / BE_NONE : byte-enable patterns for full-word / no-lane accesses
//   is_misaligned() : a word access whose low address bits are not zero
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      BYTE = 1'b0,
      WORD = 1'b1
   } size_t;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_NONE = 4'b0000;

   function automatic logic is_misaligned(input size_t size, input logic [1:0] lane);
      return (size == WORD) && (lane != 2'b00);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational lane steering between a byte-addressed access and a
// word-wide, little-endian data bus.
//   size        in   access size (BYTE / WORD)
//   lane        in   low two byte-address bits
//   store_data  in   store data from the pipeline
//   be          out  byte-lane enables for the request
//   lane_wdata  out  write data placed on the addressed lane(s)
//   word_rdata  in   aligned word returned by the responder
//   load_data   out  load result, byte loads zero-extended
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   input  logic [31:0] word_rdata,
   output logic [31:0] load_data
);

   // Byte k of the bus lives at bits [8k+7:8k] (little-endian).
   logic [7:0] rd_byte [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rd_lane
         assign rd_byte[gi] = word_rdata[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      be         = BE_NONE;
      lane_wdata = 32'h0;
      load_data  = 32'h0;
      if (size == WORD) begin
         be         = BE_WORD;
         lane_wdata = store_data;
         load_data  = word_rdata;
      end else begin
         be         = 4'b0001 << lane;
         // Replicating the byte on every lane lets the enable alone pick it.
         lane_wdata = {4{store_data[7:0]}};
         load_data  = {24'h0, rd_byte[lane]};
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store initiator. Takes one access from ex_mem, issues it
// as a request/response transaction, stalls the pipeline while it is in
// flight and presents the result to mem_wb for one cycle.
//
// Optional feature: define MEM_TIMEOUT_EN to abandon a response wait after
// TIMEOUT_CYCLES cycles and report bus_error. Without it bus_error is 0 and
// the WAIT state only exits on a response or reset.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid/in_addr/in_wdata      instruction from ex_mem
//   in_mem_read/in_mem_write       load / store (store wins)
//   in_word                        1 = word access, 0 = byte access
//   stall                          freeze earlier stages
//   out_valid/out_read_data        completion strobe and load result
//   misalign_fault/bus_error       completion status (only with out_valid)
//   mem_req_*                      request channel to the responder
//   mem_resp_valid/mem_resp_rdata  response channel from the responder
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_word,
   output logic              stall,
   output logic              out_valid,
   output logic [31:0]       out_read_data,
   output logic              misalign_fault,
   output logic              bus_error,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_we,
   output logic [3:0]        mem_req_be,
   output logic [31:0]       mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_rdata
);

   state_t            state_reg;
   logic              req_valid_reg;
   logic [ADDR_W-1:0] req_addr_reg;
   logic              req_we_reg;
   logic [3:0]        req_be_reg;
   logic [31:0]       req_wdata_reg;
   size_t             size_reg;
   logic [1:0]        lane_reg;
   logic              out_valid_reg;
   logic              misalign_reg;
   logic [31:0]       rdata_reg;

   logic  access;
   logic  misaligned;
   logic  legal;
   logic  timeout;
   size_t in_size;
   size_t align_size;
   logic [1:0]  align_lane;
   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic [31:0] align_load;

   assign access     = in_valid & (in_mem_read | in_mem_write);
   assign in_size    = in_word ? WORD : BYTE;
   assign misaligned = access & is_misaligned(in_size, in_addr[1:0]);
   assign legal      = access & ~misaligned;

   // One aligner serves both directions: in IDLE it sizes the incoming store,
   // afterwards it formats the response using the latched size and lane.
   assign align_size = (state_reg == IDLE) ? in_size : size_reg;
   assign align_lane = (state_reg == IDLE) ? in_addr[1:0] : lane_reg;

   mem_lane_align u_align (
      .size       (align_size),
      .lane       (align_lane),
      .store_data (in_wdata),
      .be         (align_be),
      .lane_wdata (align_wdata),
      .word_rdata (mem_resp_rdata),
      .load_data  (align_load)
   );

   assign stall = (state_reg == REQ) || (state_reg == WAIT) ||
                  ((state_reg == IDLE) && legal);

`ifdef MEM_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             bus_error_reg;

   // Held at zero while the request is pending so it starts fresh in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end else begin
         tmo_cnt_reg <= '0;
      end
   end

   assign timeout = (state_reg == WAIT) &&
                    (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

   // A response in the last WAIT cycle still wins over the timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_error_reg <= 1'b0;
      end else begin
         bus_error_reg <= timeout & ~mem_resp_valid;
      end
   end

   assign bus_error = bus_error_reg;
`else
   assign timeout   = 1'b0;
   assign bus_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         req_valid_reg <= 1'b0;
         req_addr_reg  <= '0;
         req_we_reg    <= 1'b0;
         req_be_reg    <= BE_NONE;
         req_wdata_reg <= 32'h0;
         size_reg      <= BYTE;
         lane_reg      <= 2'b00;
         out_valid_reg <= 1'b0;
         misalign_reg  <= 1'b0;
         rdata_reg     <= 32'h0;
      end else begin
         // Completion outputs are single-cycle pulses.
         out_valid_reg <= 1'b0;
         misalign_reg  <= 1'b0;
         rdata_reg     <= 32'h0;
         case (state_reg)
            IDLE: begin
               if (legal) begin
                  state_reg     <= REQ;
                  req_valid_reg <= 1'b1;
                  req_addr_reg  <= {in_addr[ADDR_W-1:2], 2'b00};
                  req_we_reg    <= in_mem_write;
                  req_be_reg    <= align_be;
                  req_wdata_reg <= align_wdata;
                  size_reg      <= in_size;
                  lane_reg      <= in_addr[1:0];
               end else if (in_valid) begin
                  // Non-access or misaligned word: complete locally, no bus traffic.
                  out_valid_reg <= 1'b1;
                  misalign_reg  <= misaligned;
               end
            end
            REQ: begin
               // Any response seen here is a responder protocol error and is dropped.
               if (mem_req_ready) begin
                  req_valid_reg <= 1'b0;
                  state_reg     <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
                  rdata_reg     <= req_we_reg ? 32'h0 : align_load;
               end else if (timeout) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign out_valid      = out_valid_reg;
   assign out_read_data  = rdata_reg;
   assign misalign_fault = misalign_reg;
   assign mem_req_valid  = req_valid_reg;
   assign mem_req_addr   = req_addr_reg;
   assign mem_req_we     = req_we_reg;
   assign mem_req_be     = req_be_reg;
   assign mem_req_wdata  = req_wdata_reg;

endmodule
